switch_priority_scanner: RTL and testbench
==========================================

// Module: switch_priority_scanner
// PURPOSE
//  Parametrised, clocked successor to the switch priority encoder. Synchronises and debounces
//  an NUM_IN-bit switch bus, then selects one index: highest set bit, lowest set bit, or a
//  timed round-robin scan of all set bits. Emits binary index, 2-digit BCD (for seven-segment
//  converters), popcount and flags. Sits between SWITCH_I and the display/LED logic in tops.
// PARAMETERS
//  NUM_IN          18      switch inputs, 2..99; IDX_W=$clog2(NUM_IN), CNT_W=$clog2(NUM_IN+1) derived
//  SAMPLE_DIV      50000   clock cycles per sample tick (1 ms @ 50 MHz), >=2
//  STABLE_SAMPLES  4       consecutive equal tick-samples needed to accept new vector, >=2
//  DWELL_TICKS     500     sample ticks each index is shown in scan mode, >=1
// PORTS
//  CLOCK_50_I      in   1        single clock, all logic on rising edge
//  RESETN_I        in   1        asynchronous active-low reset
//  in_bits_i       in   NUM_IN   raw switch bus (asynchronous)
//  mode_i          in   2        00 MSB-first, 01 LSB-first, 10 scan, 11 reserved (acts as 00)
//  freeze_i        in   1        1 = hold all registered outputs and scan state
//  index_o         out  IDX_W    selected bit index; all ones when invalid
//  index_bcd_o     out  8        {tens,ones} BCD of index_o; 8'hFF when invalid (blank code F)
//  valid_o         out  1        at least one debounced bit set
//  count_o         out  CNT_W    popcount of debounced vector
//  all_set_o       out  1        every debounced bit set
//  change_o        out  1        one-cycle pulse when index_o or valid_o changes
// BEHAVIOUR
//  Reset (async assert, sync release): index_o all ones, index_bcd_o 8'hFF, valid_o/all_set_o/
//   change_o/count_o 0; debounced vector 0; tick divider, stable counter, dwell counter, scan ptr 0.
//  Sync: 2-flop synchroniser per bit. Divider counts 0..SAMPLE_DIV-1; tick asserted the cycle it
//   equals SAMPLE_DIV-1, then wraps to 0.
//  Debounce (whole vector, on tick only): sample==prev_sample -> stable_cnt++ (saturate) else
//   stable_cnt=0; prev_sample<=sample. When stable_cnt reaches STABLE_SAMPLES-1 and sample !=
//   debounced, debounced<=sample. Debounce runs during freeze.
//  Encode from debounced vector, outputs registered: 1 cycle after debounced vector changes.
//   MSB: highest set index. LSB: lowest set index. None set: valid_o=0, index all ones, BCD FF.
//  Scan FSM: IDLE (none set, valid_o=0) / SHOW (ptr valid).
//   IDLE->SHOW when any bit set: ptr=lowest set bit, dwell=0.
//   SHOW: on each tick dwell++; at dwell==DWELL_TICKS-1 with tick, ptr=next set bit above ptr,
//   wrapping to lowest; single set bit -> ptr unchanged; dwell=0.
//   ptr bit cleared while shown -> next cycle ptr=next set bit above (wrap), dwell=0; none -> IDLE.
//   Entering scan mode from another mode: restart at lowest set bit, dwell=0.
//  Mode change takes effect on the next registered update (1 cycle). count_o/all_set_o follow
//   debounced vector with 1-cycle latency in all modes.
//  freeze_i=1: index_o, index_bcd_o, valid_o, count_o, all_set_o, ptr, dwell held; change_o 0.
//   On release, outputs reflect current state 1 cycle later; change_o pulses if index/valid differ.
//  BCD: tens=index/10, ones=index%10, combinational from next index, registered with index_o.
// TESTING (bench params SAMPLE_DIV=4, STABLE_SAMPLES=3, DWELL_TICKS=2, NUM_IN=18)
//  Reset: hold RESETN_I low mid-traffic -> index_o=5'h1F, index_bcd_o=8'hFF, valid_o=0, count_o=0.
//  in_bits_i bits 3 and 9 set, mode 00 -> index_o=9, BCD 8'h09, count_o=2; mode 01 -> 3 in 1 cycle.
//  Bit 5 toggled each tick for 4 ticks then held -> debounced accepts only after 3 equal samples;
//   exactly one change_o pulse.
//  Scan, bits 2,7,12 -> 2,7,12,2 each held 2 ticks; clear bit 7 while shown -> 12 next cycle.
//  All 18 bits set, mode 00 -> index_o=17, BCD 8'h17, count_o=18, all_set_o=1.
//  freeze_i=1 then change inputs -> outputs held, change_o=0; release -> update after 1 cycle.

Source files
------------

// File: rtl/switch_priority_scanner.sv
// Switch priority scanner: synchronises and debounces a switch bus, then
// reports the highest, lowest, or a timed round-robin of set bit indices
// as binary, BCD, popcount and flags. All outputs are registered.
module switch_priority_scanner #(
    parameter int NUM_IN         = 18,
    parameter int SAMPLE_DIV     = 50000,
    parameter int STABLE_SAMPLES = 4,
    parameter int DWELL_TICKS    = 500,
    localparam int IDX_W         = $clog2(NUM_IN),
    localparam int CNT_W         = $clog2(NUM_IN + 1)
) (
    input  logic              CLOCK_50_I,
    input  logic              RESETN_I,
    input  logic [NUM_IN-1:0] in_bits_i,
    input  logic [1:0]        mode_i,
    input  logic              freeze_i,
    output logic [IDX_W-1:0]  index_o,
    output logic [7:0]        index_bcd_o,
    output logic              valid_o,
    output logic [CNT_W-1:0]  count_o,
    output logic              all_set_o,
    output logic              change_o
);
    localparam int DIV_W = $clog2(SAMPLE_DIV);
    localparam int STB_W = $clog2(STABLE_SAMPLES);
    localparam int DWL_W = $clog2(DWELL_TICKS + 1);

    typedef enum logic {S_IDLE, S_SHOW} scan_t;

    logic [NUM_IN-1:0] r_sync1, r_sync2, r_prev, r_deb;
    logic [DIV_W-1:0]  r_div;
    logic [STB_W-1:0]  r_stable, w_stable_nxt;
    logic              w_tick, w_any, w_all, w_scan;
    logic [IDX_W-1:0]  w_msb, w_lsb, w_next;
    logic [CNT_W-1:0]  w_cnt;
    scan_t             r_state, w_state_nxt;
    logic [IDX_W-1:0]  r_ptr, w_ptr_nxt;
    logic [DWL_W-1:0]  r_dwell, w_dwell_nxt;
    logic [IDX_W-1:0]  w_idx_nxt, r_index;
    logic [7:0]        w_bcd_nxt, r_bcd;
    logic              w_vld_nxt, r_valid, r_all, r_change;
    logic [CNT_W-1:0]  r_count;

    assign w_tick = (r_div == DIV_W'(SAMPLE_DIV - 1));
    assign w_any  = |r_deb;
    assign w_all  = &r_deb;
    assign w_scan = (mode_i == 2'b10);

    // Two-flop synchroniser for the asynchronous switch bus
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= in_bits_i;
            r_sync2 <= r_sync1;
        end
    end

    // Sample-tick divider, wraps after SAMPLE_DIV cycles
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) r_div <= '0;
        else           r_div <= w_tick ? '0 : r_div + DIV_W'(1);
    end

    // Next stable-sample count: saturates so a long-stable vector stays accepted
    always_comb begin
        w_stable_nxt = '0;
        if (r_sync2 == r_prev)
            w_stable_nxt = (r_stable == STB_W'(STABLE_SAMPLES - 1)) ? r_stable
                                                                    : r_stable + STB_W'(1);
    end

    // Whole-vector debounce on sample ticks; keeps running while frozen
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            r_prev   <= '0;
            r_stable <= '0;
            r_deb    <= '0;
        end else if (w_tick) begin
            r_prev   <= r_sync2;
            r_stable <= w_stable_nxt;
            if (w_stable_nxt == STB_W'(STABLE_SAMPLES - 1) && r_sync2 != r_deb)
                r_deb <= r_sync2;
        end
    end

    // Priority encoders, popcount and next-set-bit-above-pointer search
    always_comb begin
        w_msb  = '0;
        w_lsb  = '0;
        w_cnt  = '0;
        for (int i = 0; i < NUM_IN; i++)
            if (r_deb[i]) begin
                w_msb = IDX_W'(i);
                w_cnt = w_cnt + CNT_W'(1);
            end
        for (int i = NUM_IN - 1; i >= 0; i--)
            if (r_deb[i]) w_lsb = IDX_W'(i);
        // wrap to the lowest set bit when nothing is set above the pointer
        w_next = w_lsb;
        for (int i = NUM_IN - 1; i >= 0; i--)
            if (r_deb[i] && (i > int'(r_ptr))) w_next = IDX_W'(i);
    end

    // Scan FSM next state; outside scan mode it parks in IDLE so entry restarts at the lowest bit
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_dwell_nxt = r_dwell;
        if (!w_scan) begin
            w_state_nxt = S_IDLE;
            w_ptr_nxt   = '0;
            w_dwell_nxt = '0;
        end else begin
            case (r_state)
                S_IDLE: if (w_any) begin
                    w_state_nxt = S_SHOW;
                    w_ptr_nxt   = w_lsb;
                    w_dwell_nxt = '0;
                end
                S_SHOW: if (!w_any) begin
                    w_state_nxt = S_IDLE;
                    w_ptr_nxt   = '0;
                    w_dwell_nxt = '0;
                end else if (!r_deb[r_ptr]) begin
                    w_ptr_nxt   = w_next;
                    w_dwell_nxt = '0;
                end else if (w_tick) begin
                    if (r_dwell == DWL_W'(DWELL_TICKS - 1)) begin
                        w_ptr_nxt   = w_next;
                        w_dwell_nxt = '0;
                    end else begin
                        w_dwell_nxt = r_dwell + DWL_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    // Scan state register, held while frozen
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            r_state <= S_IDLE;
            r_ptr   <= '0;
            r_dwell <= '0;
        end else if (!freeze_i) begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_dwell <= w_dwell_nxt;
        end
    end

    // Output selection from next-state values so mode changes land in one cycle; mode 11 behaves as 00
    always_comb begin
        if (w_scan) begin
            w_vld_nxt = (w_state_nxt == S_SHOW);
            w_idx_nxt = w_ptr_nxt;
        end else begin
            w_vld_nxt = w_any;
            w_idx_nxt = (mode_i == 2'b01) ? w_lsb : w_msb;
        end
        if (!w_vld_nxt) w_idx_nxt = '1;
        w_bcd_nxt = 8'hFF;
        if (w_vld_nxt)
            w_bcd_nxt = {4'(int'(w_idx_nxt) / 10), 4'(int'(w_idx_nxt) % 10)};
    end

    // Registered outputs; freeze holds them and suppresses the change pulse
    always_ff @(posedge CLOCK_50_I or negedge RESETN_I) begin
        if (!RESETN_I) begin
            r_index  <= '1;
            r_bcd    <= 8'hFF;
            r_valid  <= 1'b0;
            r_count  <= '0;
            r_all    <= 1'b0;
            r_change <= 1'b0;
        end else if (freeze_i) begin
            r_change <= 1'b0;
        end else begin
            r_index  <= w_idx_nxt;
            r_bcd    <= w_bcd_nxt;
            r_valid  <= w_vld_nxt;
            r_count  <= w_cnt;
            r_all    <= w_all;
            r_change <= (w_idx_nxt != r_index) || (w_vld_nxt != r_valid);
        end
    end

    assign index_o     = r_index;
    assign index_bcd_o = r_bcd;
    assign valid_o     = r_valid;
    assign count_o     = r_count;
    assign all_set_o   = r_all;
    assign change_o    = r_change;
endmodule

// File: tb/tb_switch_priority_scanner.sv
// Bench for switch_priority_scanner: every change_o pulse is matched against
// an expected entry (index, BCD, valid, count, all-set, arrival cycle).
module tb_switch_priority_scanner;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [17:0] in_bits = '0;
    logic [1:0]  mode = 2'b00;
    logic        freeze = 1'b0;
    logic [4:0]  index_o;
    logic [7:0]  index_bcd_o;
    logic        valid_o;
    logic [4:0]  count_o;
    logic        all_set_o;
    logic        change_o;

    int nchk = 0;
    int nerr = 0;
    int cyc;

    typedef struct {
        int idx; int bcd; int vld; int cnt; int all; int ecyc;
    } exp_t;
    exp_t sb[$];

    switch_priority_scanner #(
        .NUM_IN(18), .SAMPLE_DIV(4), .STABLE_SAMPLES(3), .DWELL_TICKS(2)
    ) dut (
        .CLOCK_50_I(clk), .RESETN_I(rst_n), .in_bits_i(in_bits), .mode_i(mode),
        .freeze_i(freeze), .index_o(index_o), .index_bcd_o(index_bcd_o),
        .valid_o(valid_o), .count_o(count_o), .all_set_o(all_set_o), .change_o(change_o)
    );

    always #5 clk = ~clk;

    // cycles since reset release; phase matches the DUT sample divider
    always @(posedge clk or negedge rst_n)
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;

    task automatic chk(input string tag, input int obs, input int exp);
        nchk++;
        if (obs != exp) begin
            nerr++;
            $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at cyc %0d", tag, obs, obs, exp, exp, cyc);
        end
    endtask

    task automatic push(input int idx, input int bcd, input int vld, input int cnt,
                        input int all, input int ecyc);
        exp_t e;
        e.idx = idx; e.bcd = bcd; e.vld = vld; e.cnt = cnt; e.all = all; e.ecyc = ecyc;
        sb.push_back(e);
    endtask

    task automatic drain(input int budget);
        int k = 0;
        while (sb.size() != 0 && k < budget) begin
            @(posedge clk);
            k++;
        end
        chk("sb_drain", sb.size(), 0);
        sb.delete();
    endtask

    task automatic align4();
        @(negedge clk);
        while (cyc % 4 != 0) @(negedge clk);
    endtask

    // Scoreboard monitor: each change pulse consumes one expected entry
    always @(negedge clk) begin
        if (rst_n && change_o) begin
            if (sb.size() == 0) begin
                chk("spurious_chg", int'(change_o), 0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("idx",   int'(index_o),     e.idx);
                chk("bcd",   int'(index_bcd_o), e.bcd);
                chk("valid", int'(valid_o),     e.vld);
                chk("count", int'(count_o),     e.cnt);
                chk("allset", int'(all_set_o),  e.all);
                if (e.ecyc >= 0) chk("chg_cyc", cyc, e.ecyc);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: run did not finish (cyc %0d)", cyc);
        $fatal(1);
    end

    initial begin
        int s;
        repeat (5) @(posedge clk);
        @(negedge clk);
        chk("rst_idx",   int'(index_o), 31);
        chk("rst_bcd",   int'(index_bcd_o), 'hFF);
        chk("rst_valid", int'(valid_o), 0);
        chk("rst_count", int'(count_o), 0);
        chk("rst_chg",   int'(change_o), 0);
        rst_n = 1'b1;

        // bits 3 and 9, MSB-first
        @(negedge clk);
        in_bits[3] = 1'b1; in_bits[9] = 1'b1;
        push(9, 'h09, 1, 2, 0, -1);
        drain(60);

        // LSB-first then back, one cycle each
        @(negedge clk);
        mode = 2'b01;
        push(3, 'h03, 1, 2, 0, cyc + 1);
        drain(10);
        @(negedge clk);
        mode = 2'b00;
        push(9, 'h09, 1, 2, 0, cyc + 1);
        drain(10);

        // reset mid-traffic, then re-acquire through the debouncer
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_idx",   int'(index_o), 31);
        chk("mrst_bcd",   int'(index_bcd_o), 'hFF);
        chk("mrst_valid", int'(valid_o), 0);
        chk("mrst_count", int'(count_o), 0);
        chk("mrst_all",   int'(all_set_o), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        push(9, 'h09, 1, 2, 0, cyc + 13);
        drain(60);

        // clear everything -> invalid
        @(negedge clk);
        in_bits = '0;
        push(31, 'hFF, 0, 0, 0, -1);
        drain(60);

        // bit 5 chatters once per tick for four ticks, then holds high
        align4();
        for (int k = 0; k < 4; k++) begin
            in_bits[5] = ~in_bits[5];
            repeat (4) @(negedge clk);
        end
        in_bits[5] = 1'b1;
        push(5, 'h05, 1, 1, 0, cyc + 13);
        drain(60);

        // scan over bits 2,7,12
        @(negedge clk);
        in_bits = '0;
        in_bits[2] = 1'b1; in_bits[7] = 1'b1; in_bits[12] = 1'b1;
        push(12, 'h12, 1, 3, 0, -1);
        drain(60);
        align4();
        s = cyc;
        mode = 2'b10;
        push(2,  'h02, 1, 3, 0, s + 1);
        push(7,  'h07, 1, 3, 0, s + 8);
        push(12, 'h12, 1, 3, 0, s + 16);
        push(2,  'h02, 1, 3, 0, s + 24);
        push(7,  'h07, 1, 3, 0, s + 32);
        repeat (24) @(negedge clk);
        // debounced clear lands while 7 is on show
        in_bits[7] = 1'b0;
        push(12, 'h12, 1, 2, 0, s + 37);
        push(2,  'h02, 1, 2, 0, s + 44);
        drain(100);
        @(negedge clk);
        mode = 2'b00;
        push(12, 'h12, 1, 2, 0, cyc + 1);
        drain(10);

        // freeze: inputs change, outputs hold; release updates next cycle
        @(negedge clk);
        freeze = 1'b1;
        in_bits = '1;
        repeat (30) @(negedge clk);
        chk("frz_idx",   int'(index_o), 12);
        chk("frz_bcd",   int'(index_bcd_o), 'h12);
        chk("frz_valid", int'(valid_o), 1);
        chk("frz_count", int'(count_o), 2);
        chk("frz_all",   int'(all_set_o), 0);
        chk("frz_chg",   int'(change_o), 0);
        freeze = 1'b0;
        push(17, 'h17, 1, 18, 1, cyc + 1);
        drain(10);

        // all set: LSB-first gives 0, reserved mode acts as MSB-first
        @(negedge clk);
        mode = 2'b01;
        push(0, 'h00, 1, 18, 1, cyc + 1);
        drain(10);
        @(negedge clk);
        mode = 2'b11;
        push(17, 'h17, 1, 18, 1, cyc + 1);
        drain(10);

        repeat (4) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
